// File: rtl/br_predictor_pkg.sv
// Shared types and constants for the bimodal branch predictor.
// The counter reset value, register width and default index width are kept here.
package br_predictor_pkg;

  localparam int REG_W             = 32;
  localparam int BHT_IDX_W_DEFAULT = 8;

  typedef logic [REG_W-1:0] reg_t;
  typedef logic [1:0]       bht_cnt_t;

  // Encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T
  localparam bht_cnt_t BHT_CNT_RESET = 2'b01;
  localparam bht_cnt_t BHT_CNT_MAX   = 2'b11;
  localparam bht_cnt_t BHT_CNT_MIN   = 2'b00;

  function automatic logic bht_predict(input bht_cnt_t cnt);
    return cnt[1];
  endfunction

endpackage

// File: rtl/bht_sat_counter.sv
// Combinational next-state function of a 2-bit saturating branch counter.
// Taken counts up toward strong-T, not-taken counts down toward strong-NT.
module bht_sat_counter
  import br_predictor_pkg::*;
(
  input  bht_cnt_t cnt,
  input  logic     taken,
  output bht_cnt_t next
);

  always_comb begin
    next = cnt;
    if (taken) begin
      if (cnt != BHT_CNT_MAX) next = cnt + 2'd1;
    end else begin
      if (cnt != BHT_CNT_MIN) next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/br_predictor.sv
// Bimodal branch predictor: flop table of 2-bit counters, one registered lookup
// per cycle for the fetcher and a two-stage training pipe fed by committed branches.
module br_predictor
  import br_predictor_pkg::*;
#(
  parameter int BHT_IDX_W = BHT_IDX_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_from_inst_fetcher,
  input  logic [REG_W-1:0]     pc_from_inst_fetcher,
  input  logic                 reset_from_rob_bus,
  input  logic                 valid_from_rob_bus,
  input  logic [BHT_IDX_W-1:0] pc_from_rob_bus,
  input  logic                 is_taken_from_rob_bus,
  output logic                 valid_to_inst_fetcher,
  output logic [REG_W-1:0]     pc_to_inst_fetcher,
  output logic                 is_taken_to_inst_fetcher
);

  localparam int BHT_ENTRIES = 2 ** BHT_IDX_W;

  bht_cnt_t             table_q [BHT_ENTRIES];

  logic                 u1_valid;
  logic [BHT_IDX_W-1:0] u1_idx;
  logic                 u1_taken;

  logic [BHT_IDX_W-1:0] lk_idx;
  bht_cnt_t             lk_cnt_rd;
  bht_cnt_t             lk_cnt_fwd;
  bht_cnt_t             lk_cnt;
  bht_cnt_t             wr_cnt_next;

  // Stage U1: capture the committed outcome; the table write happens one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u1_valid <= 1'b0;
      u1_idx   <= '0;
      u1_taken <= 1'b0;
    end else begin
      u1_valid <= valid_from_rob_bus;
      u1_idx   <= pc_from_rob_bus;
      u1_taken <= is_taken_from_rob_bus;
    end
  end

  bht_sat_counter u_sat_wr (
    .cnt   (table_q[u1_idx]),
    .taken (u1_taken),
    .next  (wr_cnt_next)
  );

  // Stage U2: each entry is its own flop pair so the whole table resets asynchronously.
  for (genvar g = 0; g < BHT_ENTRIES; g++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        table_q[g] <= BHT_CNT_RESET;
      end else if (u1_valid && (u1_idx == BHT_IDX_W'(g))) begin
        table_q[g] <= wr_cnt_next;
      end
    end
  end

  assign lk_idx    = pc_from_inst_fetcher[BHT_IDX_W+1:2];
  assign lk_cnt_rd = table_q[lk_idx];

  bht_sat_counter u_sat_fwd (
    .cnt   (lk_cnt_rd),
    .taken (u1_taken),
    .next  (lk_cnt_fwd)
  );

  // A write still sitting in U1 has not reached storage yet, so forward it.
  always_comb begin
    lk_cnt = lk_cnt_rd;
    if (u1_valid && (u1_idx == lk_idx)) lk_cnt = lk_cnt_fwd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_to_inst_fetcher    <= 1'b0;
      pc_to_inst_fetcher       <= '0;
      is_taken_to_inst_fetcher <= 1'b0;
    end else begin
      valid_to_inst_fetcher <= valid_from_inst_fetcher && !reset_from_rob_bus;
      if (valid_from_inst_fetcher) begin
        pc_to_inst_fetcher       <= pc_from_inst_fetcher;
        is_taken_to_inst_fetcher <= bht_predict(lk_cnt);
      end
    end
  end

endmodule

// File: tb/tb_br_predictor.sv
// Directed scoreboard bench for br_predictor: stimulus pushes expected lookup
// responses into a queue, a negedge monitor pops and compares them.
module tb_br_predictor;

  logic        clk;
  logic        rst_n;
  logic        valid_from_inst_fetcher;
  logic [31:0] pc_from_inst_fetcher;
  logic        reset_from_rob_bus;
  logic        valid_from_rob_bus;
  logic [7:0]  pc_from_rob_bus;
  logic        is_taken_from_rob_bus;
  logic        valid_to_inst_fetcher;
  logic [31:0] pc_to_inst_fetcher;
  logic        is_taken_to_inst_fetcher;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
  } exp_t;

  exp_t exp_q[$];

  br_predictor #(.BHT_IDX_W(8)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .valid_from_inst_fetcher  (valid_from_inst_fetcher),
    .pc_from_inst_fetcher     (pc_from_inst_fetcher),
    .reset_from_rob_bus       (reset_from_rob_bus),
    .valid_from_rob_bus       (valid_from_rob_bus),
    .pc_from_rob_bus          (pc_from_rob_bus),
    .is_taken_from_rob_bus    (is_taken_from_rob_bus),
    .valid_to_inst_fetcher    (valid_to_inst_fetcher),
    .pc_to_inst_fetcher       (pc_to_inst_fetcher),
    .is_taken_to_inst_fetcher (is_taken_to_inst_fetcher)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // Monitor: every presented response must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && valid_to_inst_fetcher) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid: got valid=1 pc=%h, required no response", pc_to_inst_fetcher);
        end else begin
          e = exp_q.pop_front();
          if (pc_to_inst_fetcher !== e.pc) begin
            n_fail++;
            $display("FAIL pc_echo: got %h, required %h", pc_to_inst_fetcher, e.pc);
          end
          n_tests++;
          if (is_taken_to_inst_fetcher !== e.taken) begin
            n_fail++;
            $display("FAIL taken pc=%h: got %b, required %b", e.pc, is_taken_to_inst_fetcher, e.taken);
          end
        end
      end
    end
  end

  // One clock cycle of stimulus; a lookup not killed by flush expects a response.
  task automatic cyc(input logic lv, input logic [31:0] lpc, input logic exp_taken,
                     input logic uv, input logic [7:0] uidx, input logic ut,
                     input logic fl);
    exp_t e;
    valid_from_inst_fetcher = lv;
    pc_from_inst_fetcher    = lpc;
    valid_from_rob_bus      = uv;
    pc_from_rob_bus         = uidx;
    is_taken_from_rob_bus   = ut;
    reset_from_rob_bus      = fl;
    if (lv && !fl) begin
      e.pc = lpc;
      e.taken = exp_taken;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] lpc, input logic exp_taken);
    cyc(1'b1, lpc, exp_taken, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [7:0] uidx, input logic ut);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, uidx, ut, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_outputs_clear(input string tag);
    n_tests++;
    if (valid_to_inst_fetcher !== 1'b0 || pc_to_inst_fetcher !== 32'h0 ||
        is_taken_to_inst_fetcher !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got valid=%b pc=%h taken=%b, required all zero", tag,
               valid_to_inst_fetcher, pc_to_inst_fetcher, is_taken_to_inst_fetcher);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    valid_from_inst_fetcher = 1'b0;
    pc_from_inst_fetcher    = 32'h0;
    reset_from_rob_bus      = 1'b0;
    valid_from_rob_bus      = 1'b0;
    pc_from_rob_bus         = 8'h0;
    is_taken_from_rob_bus   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_clear("reset_outputs");
    rst_n = 1'b1;
    idle(1);

    // After reset every entry is weak-NT.
    look(32'h0000_1000, 1'b0);
    idle(1);

    // Two taken updates on idx 4: 01 -> 10 -> 11.
    upd(8'h04, 1'b1);
    upd(8'h04, 1'b1);
    idle(1);
    look(32'h0000_0010, 1'b1);
    // Three more taken saturate at 11, then one not-taken gives 10.
    upd(8'h04, 1'b1);
    upd(8'h04, 1'b1);
    upd(8'h04, 1'b1);
    upd(8'h04, 1'b0);
    look(32'h0000_0010, 1'b1);
    look(32'h0000_0410, 1'b1);
    // One more not-taken: 10 -> 01, now predicts not-taken.
    upd(8'h04, 1'b0);
    idle(1);
    look(32'h0000_0010, 1'b0);

    // Same-cycle update is invisible; next cycle sees it via forwarding.
    cyc(1'b1, 32'h0000_0010, 1'b0, 1'b1, 8'h04, 1'b1, 1'b0);
    look(32'h0000_0010, 1'b1);
    look(32'h0000_0010, 1'b1);

    // Underflow: six not-taken on idx 0xFF stay at 00; one taken gives 01.
    for (int i = 0; i < 6; i++) upd(8'hFF, 1'b0);
    idle(1);
    look(32'h0000_03FC, 1'b0);
    upd(8'hFF, 1'b1);
    look(32'h0000_03FC, 1'b0);
    look(32'h0000_03FC, 1'b0);
    // A second taken reaches 10, proving the counter was at 01 not 00.
    upd(8'hFF, 1'b1);
    idle(1);
    look(32'h0000_03FC, 1'b1);

    // Flush kills the same-cycle lookup; the accompanying update still lands.
    cyc(1'b1, 32'h0000_2000, 1'b0, 1'b1, 8'h10, 1'b1, 1'b1);
    idle(1);
    look(32'h0000_0040, 1'b1);
    look(32'h0000_2000, 1'b0);
    idle(1);

    // Async reset with a lookup response live and an update pending in U1.
    cyc(1'b1, 32'h0000_0010, 1'b1, 1'b1, 8'h20, 1'b1, 1'b0);
    valid_from_rob_bus = 1'b0;
    valid_from_inst_fetcher = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs_clear("async_reset_outputs");
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs_clear("post_reset_idle");
    look(32'h0000_0010, 1'b0);
    look(32'h0000_0080, 1'b0);
    look(32'h0000_03FC, 1'b0);
    look(32'h0000_0040, 1'b0);
    idle(3);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_responses: got %0d outstanding, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
